// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer sequencer: state encodings and
// the default datapath width.
package interval_timer_ctrl_pkg;

  localparam int TIMER_WIDTH = 5;

  // Sequencer state encodings (2-bit, legacy-compatible constants)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/interval_timer_ctrl_counter.sv
// Loadable up-counter datapath. Reset clears, load has priority over enab,
// and enab increments modulo 2**WIDTH.
module interval_timer_ctrl_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out
);

  // Counter register: clear, load or increment
  always_ff @(posedge clk) begin
    if (rst)       cnt_out <= '0;
    else if (load) cnt_out <= cnt_in;
    else if (enab) cnt_out <= cnt_out + 1'b1;
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer sequencer. Latches a preload/limit/mode triple on start,
// loads the counter, advances it on step, and emits a registered tick on
// each terminal count (plus done for one-shot completion).
//
// Handshake: start is a level request honoured only in IDLE (no ready
// signal; busy=1 means any start is ignored). stop is honoured in any
// non-IDLE state and wins over terminal and step in the same cycle.
module interval_timer_ctrl
  import interval_timer_ctrl_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic             step,
  input  logic [WIDTH-1:0] preload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] preload_q;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic             tick_q;
  logic             done_q;
  logic             terminal;
  logic             ctr_load;
  logic             ctr_enab;

  // Terminal detect and counter control; load and enab are mutually exclusive
  always_comb begin
    terminal = (state == S_RUN) && step && (count == limit_q);
    ctr_load = !stop && ((state == S_LOAD) || (terminal && periodic_q));
    ctr_enab = !stop && (state == S_RUN) && step && (count != limit_q);
  end

  // Next-state selection; stop returns to IDLE from any active state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: state_nxt = stop ? S_IDLE : S_RUN;
      S_RUN: begin
        if (stop)                        state_nxt = S_IDLE;
        else if (terminal && !periodic_q) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, configuration latches and registered tick/done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      preload_q  <= '0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      tick_q <= terminal && !stop;
      done_q <= terminal && !stop && !periodic_q;
      if (state == S_IDLE && start) begin
        preload_q  <= preload;
        limit_q    <= limit;
        periodic_q <= periodic;
      end
    end
  end

  interval_timer_ctrl_counter #(.WIDTH(WIDTH)) u_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (ctr_load),
    .enab    (ctr_enab),
    .cnt_in  (preload_q),
    .cnt_out (count)
  );

  assign busy = (state != S_IDLE);
  assign tick = tick_q;
  assign done = done_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: a cycle model feeds an
// expected queue, directed scenarios check the documented timing, and a
// short random run stresses the priorities.
module tb_interval_timer_ctrl;

  localparam int W = 5;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         rst, start, stop, periodic, step;
  logic [W-1:0] preload, limit, count;
  logic         busy, tick, done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [W+2:0] exp_q[$];

  // Reference model state
  int           m_st;
  logic [W-1:0] m_cnt, m_pre, m_lim;
  logic         m_per, m_tick, m_done;

  // Observation logs indexed by cycle within a scenario
  logic [W-1:0] cnt_log[0:63];
  logic         tick_log[0:63];
  logic         done_log[0:63];
  logic         busy_log[0:63];

  // Clock and reset block
  always #5 clk = ~clk;

  interval_timer_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .step     (step),
    .preload  (preload),
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock of the reference behaviour
  task automatic model_step(input logic r, s, sp, per, stp, input logic [W-1:0] pre, lim);
    if (r) begin
      m_st = M_IDLE; m_cnt = '0; m_pre = '0; m_lim = '0; m_per = 1'b0;
      m_tick = 1'b0; m_done = 1'b0;
    end else begin
      m_tick = 1'b0;
      m_done = 1'b0;
      case (m_st)
        M_IDLE: if (s) begin
          m_pre = pre; m_lim = lim; m_per = per; m_st = M_LOAD;
        end
        M_LOAD: if (sp) m_st = M_IDLE;
                else begin m_cnt = m_pre; m_st = M_RUN; end
        M_RUN: begin
          if (sp) m_st = M_IDLE;
          else if (stp) begin
            if (m_cnt == m_lim) begin
              m_tick = 1'b1;
              if (m_per) m_cnt = m_pre;
              else begin m_done = 1'b1; m_st = M_DONE; end
            end else begin
              m_cnt = m_cnt + 1'b1;
            end
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  // Driver: apply one cycle of inputs, predict, then compare after the edge
  task automatic drive(input logic r, s, sp, per, stp, input logic [W-1:0] pre, lim);
    logic [W+2:0] e;
    rst = r; start = s; stop = sp; periodic = per; step = stp;
    preload = pre; limit = lim;
    model_step(r, s, sp, per, stp, pre, lim);
    exp_q.push_back({m_cnt, (m_st != M_IDLE), m_tick, m_done});
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("count", 32'(count), 32'(e[W+2:3]));
      check("busy",  32'(busy),  32'(e[2]));
      check("tick",  32'(tick),  32'(e[1]));
      check("done",  32'(done),  32'(e[0]));
    end
    if (cyc < 64) begin
      cnt_log[cyc] = count; tick_log[cyc] = tick;
      done_log[cyc] = done; busy_log[cyc] = busy;
    end
  endtask

  task automatic begin_test();
    cyc = 0;
    for (int i = 0; i < 64; i++) begin
      cnt_log[i] = '0; tick_log[i] = 1'b0; done_log[i] = 1'b0; busy_log[i] = 1'b0;
    end
  endtask

  function automatic int count_ones(input int lo, input int hi, input bit use_done);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += use_done ? int'(done_log[i]) : int'(tick_log[i]);
    return n;
  endfunction

  initial begin
    // Reset
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 1, 7, 9);
    check("rst_count", 32'(count), 0);
    check("rst_busy",  32'(busy),  0);
    check("rst_tick",  32'(tick),  0);

    // 1: one-shot 3..6
    begin_test();
    drive(0, 1, 0, 0, 1, 3, 6);
    repeat (9) drive(0, 0, 0, 0, 1, 3, 6);
    for (int i = 0; i < 4; i++) check("t1_seq", 32'(cnt_log[2+i]), 32'(3+i));
    check("t1_tick6",  32'(tick_log[6]), 1);
    check("t1_done6",  32'(done_log[6]), 1);
    check("t1_nticks", count_ones(1, 10, 0), 1);
    check("t1_busy6",  32'(busy_log[6]), 1);
    check("t1_busy7",  32'(busy_log[7]), 0);
    check("t1_hold",   32'(cnt_log[10]), 6);

    // 2: periodic 3..6
    begin_test();
    drive(0, 1, 0, 1, 1, 3, 6);
    repeat (15) drive(0, 0, 0, 1, 1, 3, 6);
    check("t2_tick6",  32'(tick_log[6]), 1);
    check("t2_tick10", 32'(tick_log[10]), 1);
    check("t2_tick14", 32'(tick_log[14]), 1);
    check("t2_nticks", count_ones(1, 16, 0), 3);
    check("t2_reld6",  32'(cnt_log[6]), 3);
    check("t2_reld10", 32'(cnt_log[10]), 3);
    check("t2_ndone",  count_ones(1, 16, 1), 0);
    drive(0, 0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // 3a: one-shot through wrap 30..1
    begin_test();
    drive(0, 1, 0, 0, 1, 30, 1);
    repeat (7) drive(0, 0, 0, 0, 1, 30, 1);
    check("t3_c2", 32'(cnt_log[2]), 30);
    check("t3_c3", 32'(cnt_log[3]), 31);
    check("t3_c4", 32'(cnt_log[4]), 0);
    check("t3_c5", 32'(cnt_log[5]), 1);
    check("t3_tick6",  32'(tick_log[6]), 1);
    check("t3_nticks", count_ones(1, 8, 0), 1);

    // 3b: preload == limit
    begin_test();
    drive(0, 1, 0, 0, 1, 9, 9);
    repeat (4) drive(0, 0, 0, 0, 1, 9, 9);
    check("t3b_tick3", 32'(tick_log[3]), 1);
    check("t3b_done3", 32'(done_log[3]), 1);
    check("t3b_busy4", 32'(busy_log[4]), 0);
    check("t3b_hold",  32'(cnt_log[5]), 9);

    // 4: periodic with step toggling 1,0,1,0...
    begin_test();
    drive(0, 1, 0, 1, 1, 3, 6);
    for (int k = 1; k < 24; k++) drive(0, 0, 0, 1, (k % 2 == 0), 3, 6);
    check("t4_tick9",  32'(tick_log[9]), 1);
    check("t4_tick17", 32'(tick_log[17]), 1);
    check("t4_nticks", count_ones(1, 24, 0), 2);
    check("t4_reld9",  32'(cnt_log[9]), 3);
    drive(0, 0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // 5a: stop at count=4, periodic
    begin_test();
    drive(0, 1, 0, 1, 1, 3, 6);
    repeat (2) drive(0, 0, 0, 1, 1, 3, 6);
    check("t5_c3", 32'(cnt_log[3]), 4);
    drive(0, 0, 1, 1, 1, 3, 6);
    check("t5_busy4", 32'(busy_log[4]), 0);
    check("t5_hold4", 32'(cnt_log[4]), 4);
    repeat (3) drive(0, 0, 0, 1, 1, 3, 6);
    check("t5_nticks", count_ones(1, 7, 0), 0);
    check("t5_hold7",  32'(cnt_log[7]), 4);

    // 5b: stop on the terminal cycle
    begin_test();
    drive(0, 1, 0, 1, 1, 3, 6);
    repeat (4) drive(0, 0, 0, 1, 1, 3, 6);
    check("t5b_c5", 32'(cnt_log[5]), 6);
    drive(0, 0, 1, 1, 1, 3, 6);
    check("t5b_notick", 32'(tick_log[6]), 0);
    check("t5b_busy6",  32'(busy_log[6]), 0);
    check("t5b_hold6",  32'(cnt_log[6]), 6);
    repeat (2) drive(0, 0, 0, 0, 1, 3, 6);

    // 6a: reset mid-run at count=5
    begin_test();
    drive(0, 1, 0, 1, 1, 3, 10);
    repeat (3) drive(0, 0, 0, 1, 1, 3, 10);
    check("t6_c4", 32'(cnt_log[4]), 5);
    drive(1, 0, 0, 1, 1, 3, 10);
    check("t6_rcnt",  32'(cnt_log[5]), 0);
    check("t6_rbusy", 32'(busy_log[5]), 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // 6b: start while busy is ignored
    begin_test();
    drive(0, 1, 0, 1, 1, 3, 6);
    repeat (2) drive(0, 0, 0, 1, 1, 3, 6);
    drive(0, 1, 0, 0, 1, 0, 15);
    repeat (8) drive(0, 0, 0, 0, 1, 0, 15);
    check("t6b_tick6",  32'(tick_log[6]), 1);
    check("t6b_tick10", 32'(tick_log[10]), 1);
    check("t6b_reld6",  32'(cnt_log[6]), 3);
    check("t6b_ndone",  count_ones(1, 11, 1), 0);
    drive(0, 0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Random run against the model
    begin_test();
    for (int k = 0; k < 120; k++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0),
            W'($urandom_range(0, 31)), W'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
